sonar_ping_tx: RTL and testbench

// - Transmit side of the sonar: drives the transducer H-bridge with a burst of complementary square-wave cycles.
// - Holds the receiver blanked while the burst rings down, then releases it.
// - Emits a 1-clock pingSync that restarts the sample-capture address, so the echo trace is time-aligned to the ping.
// - Lives beside the ADC capture path and runs on the 16 MHz ADC clock domain.

---
 rtl/sonar_ping_tx.sv | 163 ++++++++++++++++
 tb/tb_sonar_ping_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ping_tx.sv
// Sonar transmit burst generator: complementary H-bridge drive, ring-down blanking, ping sync/done pulses.
// Optional free-running auto-ping timer is enabled with `define SONAR_AUTO_PING_EN.
`timescale 1ns/1ps

module sonar_ping_tx #(
  parameter int unsigned HALF_DIV     = 200,
  parameter int unsigned DEAD_TIME    = 4,
  parameter int unsigned BLANK_CYCLES = 3200,
  parameter int unsigned PING_PERIOD  = 800000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       trigger,
  input  logic       abort,
  input  logic [7:0] burstLen,
  output logic       txP,
  output logic       txN,
  output logic       blank,
  output logic       busy,
  output logic       pingSync,
  output logic       done
);

  // Illegal parameter sets stop elaboration rather than producing overlapping bridge legs or wrapping counters.
  generate
    if (DEAD_TIME >= HALF_DIV || HALF_DIV > 65536 || BLANK_CYCLES > 65535 ||
        PING_PERIOD == 0 || PING_PERIOD > 1048576) begin : g_bad_params
      $error("sonar_ping_tx: illegal parameter combination");
    end
  endgenerate

  localparam logic [15:0] HALF_LAST  = 16'(HALF_DIV - 1);
  localparam logic [15:0] DEAD_CMP   = 16'(DEAD_TIME);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK, S_DONE} state_t;

  state_t      state;
  logic [15:0] phase_cnt;
  logic [8:0]  half_cnt;
  logic [7:0]  len;

  logic        auto_req;
  logic        start_req;
  logic [7:0]  start_len;
  logic        phase_wrap;
  logic [15:0] phase_next;
  logic [8:0]  half_next;
  logic        drive_end;
  logic        next_on;

`ifdef SONAR_AUTO_PING_EN
  localparam logic [19:0] PING_LAST = 20'(PING_PERIOD - 1);
  logic [19:0] ping_timer;

  // Free-running period timer; deliberately untouched by abort.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ping_timer <= '0;
    end else if (ping_timer == PING_LAST) begin
      ping_timer <= '0;
    end else begin
      ping_timer <= ping_timer + 20'd1;
    end
  end

  assign auto_req = (ping_timer == PING_LAST);
`else
  assign auto_req = 1'b0;
`endif

  // Outputs are registered from the next counter values so they line up with the state they describe.
  always_comb begin
    start_req  = trigger | auto_req;
    start_len  = (burstLen == 8'd0) ? 8'd1 : burstLen;
    phase_wrap = (phase_cnt == HALF_LAST);
    phase_next = phase_wrap ? 16'd0 : phase_cnt + 16'd1;
    half_next  = phase_wrap ? half_cnt + 9'd1 : half_cnt;
    drive_end  = phase_wrap && (half_cnt == {len - 8'd1, 1'b1});
    next_on    = (phase_next >= DEAD_CMP);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      half_cnt  <= '0;
      len       <= '0;
      txP       <= 1'b0;
      txN       <= 1'b0;
      blank     <= 1'b0;
      busy      <= 1'b0;
      pingSync  <= 1'b0;
      done      <= 1'b0;
    end else begin
      pingSync <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req && !abort) begin
            state     <= S_DRIVE;
            len       <= start_len;
            phase_cnt <= '0;
            half_cnt  <= '0;
            busy      <= 1'b1;
            blank     <= 1'b1;
            pingSync  <= 1'b1;
            txP       <= (DEAD_TIME == 0);
            txN       <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state <= S_IDLE;
            txP   <= 1'b0;
            txN   <= 1'b0;
            blank <= 1'b0;
            busy  <= 1'b0;
          end else if (drive_end) begin
            txP       <= 1'b0;
            txN       <= 1'b0;
            phase_cnt <= '0;
            if (BLANK_CYCLES == 0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              blank <= 1'b0;
            end else begin
              state <= S_BLANK;
            end
          end else begin
            phase_cnt <= phase_next;
            half_cnt  <= half_next;
            txP       <= next_on & ~half_next[0];
            txN       <= next_on & half_next[0];
          end
        end
        S_BLANK: begin
          if (abort) begin
            state <= S_IDLE;
            blank <= 1'b0;
            busy  <= 1'b0;
          end else if (phase_cnt == BLANK_LAST) begin
            state     <= S_DONE;
            phase_cnt <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
            blank     <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_ping_tx.sv
// Bench for sonar_ping_tx: ping-timeline model compared every cycle plus hand-computed timing points.
// A second small instance exercises the SONAR_AUTO_PING_EN period (or its absence).
`timescale 1ns/1ps

module tb_sonar_ping_tx;

  localparam int H  = 200;
  localparam int DT = 4;
  localparam int B  = 3200;

  logic       clk = 1'b0;
  logic       nRST;
  logic       trigger;
  logic       abort;
  logic [7:0] burstLen;
  logic       txP, txN, blank, busy, pingSync, done;

  logic       rst2_n;
  logic       a_txp, a_txn, a_blank, a_busy, a_sync, a_done;

  always #5 clk = ~clk;

  sonar_ping_tx u_dut (
    .clk      (clk),
    .nRST     (nRST),
    .trigger  (trigger),
    .abort    (abort),
    .burstLen (burstLen),
    .txP      (txP),
    .txN      (txN),
    .blank    (blank),
    .busy     (busy),
    .pingSync (pingSync),
    .done     (done)
  );

  sonar_ping_tx #(
    .HALF_DIV     (10),
    .DEAD_TIME    (4),
    .BLANK_CYCLES (50),
    .PING_PERIOD  (2000)
  ) u_auto (
    .clk      (clk),
    .nRST     (rst2_n),
    .trigger  (1'b0),
    .abort    (1'b0),
    .burstLen (8'd1),
    .txP      (a_txp),
    .txN      (a_txn),
    .blank    (a_blank),
    .busy     (a_busy),
    .pingSync (a_sync),
    .done     (a_done)
  );

  // Ping timeline model: a ping is just a start cycle and a length; outputs follow from the offset into it.
  int ec = 0;
  bit m_act = 1'b0;
  int m_start = 0;
  int m_len = 1;

  always @(posedge clk) begin : model
    int k;
    int dl;
    bit idle;
    if (!nRST) begin
      m_act = 1'b0;
    end else begin
      k    = ec - m_start;
      dl   = 2 * m_len * H;
      idle = !m_act || (k > dl + B);
      if (m_act && k < dl + B && abort) begin
        m_act = 1'b0;
      end else if (idle && trigger && !abort) begin
        m_act   = 1'b1;
        m_start = ec + 1;
        m_len   = (burstLen == 8'd0) ? 1 : int'(burstLen);
      end
    end
    ec = ec + 1;
  end

  // Order: {txP, txN, blank, busy, pingSync, done}
  function automatic logic [5:0] model_out(input int c);
    int k;
    int dl;
    bit on;
    bit odd;
    if (!m_act) return 6'b0;
    k  = c - m_start;
    dl = 2 * m_len * H;
    if (k < dl) begin
      on  = (k % H) >= DT;
      odd = ((k / H) % 2) == 1;
      return {on && !odd, on && odd, 1'b1, 1'b1, k == 0, 1'b0};
    end
    if (k < dl + B) return 6'b001100;
    if (k == dl + B) return 6'b000001;
    return 6'b0;
  endfunction

  typedef struct {
    int         at;
    logic [5:0] mask;
    logic [5:0] val;
    string      name;
  } lit_t;

  lit_t exp_q[$];
  int   lit_idx = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   finish_req = 1'b0;
  bit   final_done = 1'b0;
  bit   a_seen = 1'b0;
  int   a_last = 0;
  int   a_count = 0;

  always begin : compare
    bit         from_clk;
    logic [5:0] got;
    logic [5:0] want;
    @(negedge clk or negedge nRST);
    from_clk = (clk == 1'b0);
    #1;
    got  = {txP, txN, blank, busy, pingSync, done};
    want = nRST ? model_out(ec) : 6'b0;
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s ec=%0d got=%b want=%b", from_clk ? "cycle" : "async_reset", ec, got, want);
    end
    n_cmp++;
    if ((txP & txN) !== 1'b0) begin
      n_bad++;
      $display("FAIL leg_overlap ec=%0d got txP&txN=%b want 0", ec, txP & txN);
    end
    if (from_clk) begin
      while (lit_idx < exp_q.size() && exp_q[lit_idx].at <= ec) begin
        n_cmp++;
        if (exp_q[lit_idx].at != ec) begin
          n_bad++;
          $display("FAIL %s missed: at=%0d ec=%0d", exp_q[lit_idx].name, exp_q[lit_idx].at, ec);
        end else if ((got & exp_q[lit_idx].mask) !== (exp_q[lit_idx].val & exp_q[lit_idx].mask)) begin
          n_bad++;
          $display("FAIL %s ec=%0d got=%b want=%b mask=%b", exp_q[lit_idx].name, ec,
                   got & exp_q[lit_idx].mask, exp_q[lit_idx].val & exp_q[lit_idx].mask, exp_q[lit_idx].mask);
        end
        lit_idx++;
      end
      n_cmp++;
      if ((a_txp & a_txn) !== 1'b0) begin
        n_bad++;
        $display("FAIL auto_leg_overlap ec=%0d got=%b want 0", ec, a_txp & a_txn);
      end
`ifdef SONAR_AUTO_PING_EN
      if (a_sync) begin
        if (a_seen) begin
          n_cmp++;
          if (ec - a_last != 2000) begin
            n_bad++;
            $display("FAIL auto_period ec=%0d got=%0d want=2000", ec, ec - a_last);
          end
        end
        a_seen  = 1'b1;
        a_last  = ec;
        a_count = a_count + 1;
      end
`else
      n_cmp++;
      if (a_sync !== 1'b0) begin
        n_bad++;
        $display("FAIL auto_absent ec=%0d got pingSync=%b want 0", ec, a_sync);
      end
`endif
      if (finish_req && !final_done) begin
        n_cmp++;
        if (lit_idx != exp_q.size()) begin
          n_bad++;
          $display("FAIL literals_pending got=%0d want=%0d", lit_idx, exp_q.size());
        end
`ifdef SONAR_AUTO_PING_EN
        n_cmp++;
        if (a_count < 10) begin
          n_bad++;
          $display("FAIL auto_count got=%0d want>=10", a_count);
        end
`endif
        final_done = 1'b1;
      end
    end
  end

  task automatic push_exp(input int at, input logic [5:0] mask, input logic [5:0] val, input string name);
    lit_t e;
    e.at   = at;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One-clock trigger; returns the cycle id of the first DRIVE cycle (the pingSync cycle).
  task automatic pulse_trigger(input logic [7:0] len, output int base);
    @(negedge clk);
    trigger  = 1'b1;
    burstLen = len;
    @(negedge clk);
    trigger = 1'b0;
    base    = ec;
  endtask

  initial begin : stimulus
    int b;
    nRST     = 1'b0;
    rst2_n   = 1'b0;
    trigger  = 1'b0;
    abort    = 1'b0;
    burstLen = 8'd0;
    repeat (3) @(negedge clk);
    nRST   = 1'b1;
    rst2_n = 1'b1;
    repeat (5) @(negedge clk);

    // burstLen=2: two full cycles, 800 drive clocks, 3200 blank, done on the 4001st clock
    pulse_trigger(8'd2, b);
    push_exp(b,        6'b111111, 6'b001110, "sync_first");
    push_exp(b + 3,    6'b110000, 6'b000000, "dead_time");
    push_exp(b + 4,    6'b110000, 6'b100000, "txp_rise");
    push_exp(b + 199,  6'b110000, 6'b100000, "txp_last");
    push_exp(b + 200,  6'b110000, 6'b000000, "half_dead");
    push_exp(b + 204,  6'b110000, 6'b010000, "txn_rise");
    push_exp(b + 399,  6'b110000, 6'b010000, "txn_last");
    push_exp(b + 404,  6'b110000, 6'b100000, "second_txp");
    push_exp(b + 799,  6'b110000, 6'b010000, "final_txn");
    push_exp(b + 800,  6'b111111, 6'b001100, "blank_start");
    push_exp(b + 3999, 6'b001101, 6'b001100, "blank_last");
    push_exp(b + 4000, 6'b111111, 6'b000001, "done_pulse");
    push_exp(b + 4001, 6'b111111, 6'b000000, "idle_after");
    repeat (4005) @(negedge clk);

    // burstLen=0 behaves as 1; a mid-ping burstLen change must be ignored
    pulse_trigger(8'd0, b);
    push_exp(b,        6'b111111, 6'b001110, "len0_sync");
    push_exp(b + 204,  6'b110000, 6'b010000, "len0_txn");
    push_exp(b + 400,  6'b111111, 6'b001100, "len0_blank");
    push_exp(b + 3600, 6'b111111, 6'b000001, "len0_done");
    repeat (10) @(negedge clk);
    burstLen = 8'd5;
    repeat (3600) @(negedge clk);

    // trigger held high: one pingSync per ping, next one two clocks after done
    @(negedge clk);
    trigger  = 1'b1;
    burstLen = 8'd1;
    @(negedge clk);
    b = ec;
    push_exp(b,        6'b000010, 6'b000010, "held_sync");
    push_exp(b + 1,    6'b000010, 6'b000000, "held_single");
    push_exp(b + 3600, 6'b000111, 6'b000001, "held_done");
    push_exp(b + 3601, 6'b000010, 6'b000000, "held_gap");
    push_exp(b + 3602, 6'b000110, 6'b000110, "held_resync");
    repeat (3612) @(negedge clk);
    trigger = 1'b0;
    repeat (3600) @(negedge clk);

    // abort on drive clock 300 (second half, txN active)
    pulse_trigger(8'd2, b);
    repeat (299) @(negedge clk);
    push_exp(b + 299, 6'b111100, 6'b011100, "pre_abort");
    push_exp(b + 300, 6'b111111, 6'b000000, "abort_kill");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (200) @(negedge clk);
    pulse_trigger(8'd1, b);
    push_exp(b,        6'b111111, 6'b001110, "post_abort_sync");
    push_exp(b + 3600, 6'b111111, 6'b000001, "post_abort_done");
    repeat (3605) @(negedge clk);

    // async reset in the middle of blanking
    pulse_trigger(8'd1, b);
    repeat (999) @(negedge clk);
    @(posedge clk);
    #2;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (4) @(negedge clk);
    pulse_trigger(8'd1, b);
    push_exp(b,        6'b111111, 6'b001110, "post_reset_sync");
    push_exp(b + 4,    6'b110000, 6'b100000, "post_reset_txp");
    push_exp(b + 3600, 6'b111111, 6'b000001, "post_reset_done");
    repeat (3605) @(negedge clk);

    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
